// File: rtl/reaction_round_controller.sv
// reaction_round_controller
//   Multi-round reaction-time game sequencer. Each round shows red for a
//   loaded delay, then green while a score counter runs. The round score
//   (or PENALTY on a false start) is written to the register file. After
//   ROUNDS rounds the best (minimum) score is written at address ROUNDS
//   and the block halts in DONE until the next start edge.
//
// Ports
//   Clock            : rising-edge clock
//   buttonReset      : asynchronous active-high reset
//   buttonStart      : start button level (edge-detected internally)
//   buttonHit        : hit button level (edge-detected internally)
//   delayLoad        : WAIT duration in cycles, sampled on WAIT entry (0 acts as 1)
//   RedLed           : high in WAIT
//   ledGreen         : high in GO
//   registerLoad     : register-file write enable (STORE and FINAL)
//   WriteAddress     : register-file write address
//   registerLoadData : register-file write data
//   roundIndex       : current round, 0..ROUNDS-1
//   bestScore        : minimum score of the current game
//   falseStart       : one-cycle pulse coinciding with the STORE of a false start
//   gameDone         : high in DONE
module reaction_round_controller #(
  parameter int SCORE_W = 13,
  parameter int DELAY_W = 13,
  parameter int ROUNDS  = 4,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic               Clock,
  input  logic               buttonReset,
  input  logic               buttonStart,
  input  logic               buttonHit,
  input  logic [DELAY_W-1:0] delayLoad,
  output logic               RedLed,
  output logic               ledGreen,
  output logic               registerLoad,
  output logic [ADDR_W-1:0]  WriteAddress,
  output logic [SCORE_W-1:0] registerLoadData,
  output logic [ADDR_W-1:0]  roundIndex,
  output logic [SCORE_W-1:0] bestScore,
  output logic               falseStart,
  output logic               gameDone
);

  localparam logic [SCORE_W-1:0] PENALTY    = '1;
  localparam logic [SCORE_W-1:0] TIMEOUT_V  = SCORE_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0]  LAST_ROUND = ADDR_W'(ROUNDS - 1);
  localparam logic [ADDR_W-1:0]  FINAL_ADDR = ADDR_W'(ROUNDS);
  localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_STORE,
    S_FINAL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               start_prev_q, hit_prev_q;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ADDR_W-1:0]  round_q, round_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SCORE_W-1:0] data_q, data_d;
  logic               false_start_q, false_start_d;

  logic               start_edge, hit_edge;
  logic [DELAY_W-1:0] delay_init;
  logic [SCORE_W-1:0] best_min;

  assign start_edge = buttonStart & ~start_prev_q;
  assign hit_edge   = buttonHit & ~hit_prev_q;
  assign delay_init = (delayLoad == '0) ? DELAY_ONE : delayLoad;
  // data_q holds the score written in the current STORE cycle
  assign best_min   = (data_q < best_q) ? data_q : best_q;

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    score_d       = score_q;
    round_d       = round_q;
    best_d        = best_q;
    addr_d        = addr_q;
    data_d        = data_q;
    false_start_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d = S_WAIT;
          round_d = '0;
          best_d  = PENALTY;
          delay_d = delay_init;
        end
      end

      S_WAIT: begin
        if (hit_edge) begin
          state_d       = S_STORE;
          false_start_d = 1'b1;
          addr_d        = round_q;
          data_d        = PENALTY;
        end else if (delay_q <= DELAY_ONE) begin
          state_d = S_GO;
          score_d = '0;
        end else begin
          delay_d = delay_q - DELAY_ONE;
        end
      end

      S_GO: begin
        if (hit_edge || (score_q == TIMEOUT_V)) begin
          state_d = S_STORE;
          addr_d  = round_q;
          data_d  = score_q;
        end else begin
          score_d = score_q + SCORE_W'(1);
        end
      end

      S_STORE: begin
        best_d = best_min;
        if (round_q == LAST_ROUND) begin
          state_d = S_FINAL;
          addr_d  = FINAL_ADDR;
          data_d  = best_min;
        end else begin
          state_d = S_WAIT;
          round_d = round_q + ADDR_W'(1);
          delay_d = delay_init;
        end
      end

      S_FINAL: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge buttonReset) begin
    if (buttonReset) begin
      state_q       <= S_IDLE;
      start_prev_q  <= 1'b1;
      hit_prev_q    <= 1'b1;
      delay_q       <= '0;
      score_q       <= '0;
      round_q       <= '0;
      best_q        <= PENALTY;
      addr_q        <= '0;
      data_q        <= '0;
      false_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= buttonStart;
      hit_prev_q    <= buttonHit;
      delay_q       <= delay_d;
      score_q       <= score_d;
      round_q       <= round_d;
      best_q        <= best_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      false_start_q <= false_start_d;
    end
  end

  assign RedLed           = (state_q == S_WAIT);
  assign ledGreen         = (state_q == S_GO);
  assign registerLoad     = (state_q == S_STORE) || (state_q == S_FINAL);
  assign gameDone         = (state_q == S_DONE);
  assign WriteAddress     = addr_q;
  assign registerLoadData = data_q;
  assign roundIndex       = round_q;
  assign bestScore        = best_q;
  assign falseStart       = false_start_q;

endmodule

// File: doc/reaction_round_controller.md
# reaction_round_controller

Parametrised multi-round reaction-time game controller. It sequences IDLE → WAIT (red) → GO (green, timing) → STORE for `ROUNDS` rounds, then writes the best score and halts in DONE. Delay and score counting, false-start penalty, timeout and best-score tracking are all internal. The block drives the register-file write port directly.

## Interface
- `SCORE_W`, 13, score width; scores saturate at `2^SCORE_W-1` (PENALTY)
- `DELAY_W`, 13, width of the random-delay input
- `ROUNDS`, 4, rounds per game; must satisfy `ROUNDS <= 2^ADDR_W-1`
- `ADDR_W`, 3, register-file address width
- `TIMEOUT`, 4095, maximum score before forced store; must satisfy `TIMEOUT < 2^SCORE_W-1`
- `Clock` in 1: the only clock; all state changes on its rising edge
- `buttonReset` in 1: asynchronous, active-high reset
- `buttonStart` in 1: level input, synchronous to `Clock`; the block edge-detects it internally
- `buttonHit` in 1: level input, synchronous to `Clock`; the block edge-detects it internally
- `delayLoad` in DELAY_W: WAIT duration in cycles, sampled on WAIT entry
- `RedLed` out 1: high in WAIT
- `ledGreen` out 1: high in GO
- `registerLoad` out 1: register-file write enable
- `WriteAddress` out ADDR_W: write address
- `registerLoadData` out SCORE_W: write data
- `roundIndex` out ADDR_W: current round, 0..ROUNDS-1
- `bestScore` out SCORE_W: minimum score of the current game
- `falseStart` out 1: one-cycle pulse on a false start
- `gameDone` out 1: high in DONE

## Operation
- States: IDLE, WAIT, GO, STORE, FINAL, DONE.
- Edge detection: a rising edge is `btn & ~btn_prev`. Both `btn_prev` registers reset to 1, so a button held through reset does not trigger.
- IDLE or DONE, start edge → WAIT. On this transition: `roundIndex`=0, `bestScore`=PENALTY. A start edge in any other state is ignored.
- WAIT entry: delay counter is loaded with `delayLoad`; a value of 0 is treated as 1. The counter decrements once per cycle. The cycle in which it equals 1 is the last WAIT cycle → GO.
- WAIT, hit edge → STORE with score=PENALTY. `falseStart` pulses in that same cycle. The hit edge takes priority over delay expiry.
- GO entry: score counter = 0; it increments once per GO cycle.
  - Hit edge → STORE with score = counter value in that cycle.
  - Otherwise, counter == TIMEOUT → STORE with score=TIMEOUT.
  - If both happen in the same cycle, the hit wins; the score is the same either way.
- STORE (1 cycle):
  - Outputs: `registerLoad`=1, `WriteAddress`=`roundIndex`, `registerLoadData`=score.
  - `bestScore` ← min(`bestScore`, score).
  - If `roundIndex`==ROUNDS-1 → FINAL; else `roundIndex`++ and → WAIT, which reloads `delayLoad`.
- FINAL (1 cycle): `registerLoad`=1, `WriteAddress`=ROUNDS, `registerLoadData`=min(`bestScore`, last score) → DONE.
- DONE: `gameDone`=1. `bestScore` and `roundIndex` hold until the next start edge.
- Hit edges in IDLE, STORE, FINAL and DONE are ignored.

## Timing
- Reset values (asynchronous, immediate): state=IDLE; all 1-bit outputs 0; `WriteAddress`=0; `registerLoadData`=0; `roundIndex`=0; `bestScore`=PENALTY; both counters 0.
- Reset mid-game abandons the game. No write occurs, and `registerLoad` drops immediately.
- All outputs are Moore outputs, except that `falseStart`, `registerLoadData` and `WriteAddress` are registered so they align with state.
- `RedLed` is high for exactly max(`delayLoad`,1) cycles when no hit occurs.
- Score latency: a hit edge in the first `ledGreen` cycle gives score 0. STORE follows the hit-edge cycle by 1 cycle.
- Worst case per round: delay + TIMEOUT+1 + 1 cycles.
- `registerLoad` is high for exactly ROUNDS+1 single cycles per game.

## Test plan
- Reset with `buttonHit` held high, then release reset → no `falseStart`; state remains IDLE; all outputs at reset values.
- ROUNDS=4, `delayLoad`=5, hits 3,7,2,9 cycles after `ledGreen` rises → writes addr0..3 = 3,7,2,9; addr4=2; `bestScore`=2; `gameDone`=1.
- Hit edge during `RedLed` in round 1 → `falseStart` pulses; addr1=8191 (PENALTY); next round proceeds normally.
- No hit in GO with TIMEOUT=20 → `ledGreen` high 21 cycles; stored score 20.
- `delayLoad`=0 → `RedLed` high for 1 cycle; start edge asserted mid-GO → ignored.
- `buttonReset` asserted during STORE of round 2 → `registerLoad` falls immediately; state IDLE; next start edge begins at round 0 with `bestScore`=8191.
